// File: rtl/i2s2_tx_if.sv
// Sample handshake between the synthesizer and the I2S transmitter.
// A sample moves on every rising clk_in edge where sample_valid_in and sample_ready_out are both high; the master holds sample_in and valid steady until then.
interface i2s2_tx_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid_in;
  logic             sample_ready_out;

  modport master (
    output sample_in,
    output sample_valid_in,
    input  sample_ready_out
  );

  modport slave (
    input  sample_in,
    input  sample_valid_in,
    output sample_ready_out
  );
endinterface

// File: rtl/i2s2_tx.sv
// Mono I2S transmitter: one held sample per 1024-cycle frame, sent on both channels, 24-bit slots, MSB first.
// Build option I2S2_MUTE_ON_UNDERRUN_EN: on an underrun frame send silence instead of repeating the last sample.
module i2s2_tx #(
  parameter int WIDTH = 16
) (
  input  logic      clk_in,
  input  logic      rst_in,
  i2s2_tx_if.slave  up,
  output logic      mclk_out,
  output logic      lrck_out,
  output logic      sclk_out,
  output logic      sdin_out,
  output logic      underrun_out
);

  if (WIDTH < 8 || WIDTH > 24) begin : g_bad_width
    $error("i2s2_tx: WIDTH must be in 8..24");
  end

  logic [9:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             sdin_q, sdin_d;
  logic             underrun_q, underrun_d;

  logic             frame_load;
  logic             bit_edge;
  logic             accept;
  logic [4:0]       next_slot;
  logic [4:0]       bit_idx;
  logic [23:0]      word;

  assign up.sample_ready_out = !hold_full_q && !rst_in;

  // The codec clocks are plain counter bits, so they come straight off flops.
  assign mclk_out     = cnt_q[1];
  assign sclk_out     = cnt_q[3];
  assign lrck_out     = cnt_q[9];
  assign sdin_out     = sdin_q;
  assign underrun_out = underrun_q;

  always_comb begin
    cnt_d       = cnt_q + 10'd1;
    frame_load  = (cnt_q == 10'd1023);
    bit_edge    = (cnt_q[3:0] == 4'hF);
    accept      = up.sample_valid_in && up.sample_ready_out;

    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    active_d    = active_q;
    underrun_d  = 1'b0;

    if (frame_load) begin
      if (hold_full_q) begin
        active_d    = hold_q;
        hold_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
`ifdef I2S2_MUTE_ON_UNDERRUN_EN
        active_d   = '0;
`else
        active_d   = active_q;
`endif
      end
    end

    // Hold is only empty-and-ready here, so a capture on the load edge waits a frame.
    if (accept) begin
      hold_d      = up.sample_in;
      hold_full_d = 1'b1;
    end
  end

  // Serialiser: slot 0 is the I2S delay bit, slots 1..24 the left-justified word.
  always_comb begin
    word      = 24'(active_q) << (24 - WIDTH);
    next_slot = cnt_d[8:4];
    bit_idx   = 5'd24 - next_slot;
    sdin_d    = sdin_q;
    if (bit_edge) begin
      if (next_slot >= 5'd1 && next_slot <= 5'd24) begin
        sdin_d = word[bit_idx];
      end else begin
        sdin_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      active_q    <= '0;
      sdin_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      active_q    <= active_d;
      sdin_q      <= sdin_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule
